output_backprop: RTL and testbench

//  Backward-pass engine for the single output neuron. On each backprop request

---
 rtl/output_backprop.sv | 100 ++++++++++
 tb/tb_output_backprop.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/output_backprop.sv
// output_backprop: backward pass for the output neuron; walks the output weights one per cycle,
// applying w_k -= (err*x_k) >>> LR_SHIFT with saturation, and emits the hidden error per weight.
module output_backprop #(
    parameter int N_HIDDEN = 8,
    parameter int X_W      = 10,
    parameter int W_W      = 8,
    parameter int ERR_W    = 12,
    parameter int LR_SHIFT = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      en_i,
    input  logic                      init_i,
    input  logic                      start_i,
    input  logic [ERR_W-1:0]          err_i,
    input  logic [N_HIDDEN*X_W-1:0]   x_flat_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      herr_valid_o,
    output logic [2:0]                herr_idx_o,
    output logic [ERR_W-1:0]          herr_o,
    output logic [N_HIDDEN*W_W-1:0]   w_flat_o
);
    localparam int P_W = ERR_W + X_W + 1;
    localparam int H_W = ERR_W + W_W;
    localparam logic signed [P_W:0]   W_MAX = (P_W+1)'(2**(W_W-1) - 1);
    localparam logic signed [P_W:0]   W_MIN = (P_W+1)'(-(2**(W_W-1)));
    localparam logic signed [H_W-1:0] H_MAX = H_W'(2**(ERR_W-1) - 1);
    localparam logic signed [H_W-1:0] H_MIN = H_W'(-(2**(ERR_W-1)));

    function automatic logic [N_HIDDEN*W_W-1:0] def_w();
        def_w = '0;
        for (int i = 0; i < N_HIDDEN; i++) def_w[i*W_W +: W_W] = W_W'(i + 1);
    endfunction
    localparam logic [N_HIDDEN*W_W-1:0] W_DEF = def_w();

    typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_t;
    state_t state_q, state_d;

    logic [2:0]              k_q;
    logic [ERR_W-1:0]        err_q;
    logic [N_HIDDEN*X_W-1:0] x_q;
    logic [W_W-1:0]          w_k, w_new;
    logic [ERR_W-1:0]        herr_new;
    logic signed [P_W-1:0]   p, d;
    logic signed [P_W:0]     diff;
    logic signed [H_W-1:0]   hp, hd;

    assign busy_o = state_q != IDLE;

    always_comb begin
        state_d = state_q;
        if (en_i)
            state_d = state_q == IDLE   ? (start_i ? UPDATE : IDLE) :
                      state_q == UPDATE ? (k_q == 3'(N_HIDDEN-1) ? DONE : UPDATE) : IDLE;
    end

    // x_k is zero-extended so the product stays signed; shifts floor toward -inf
    always_comb begin
        w_k      = w_flat_o[k_q*W_W +: W_W];
        p        = P_W'($signed(err_q)) * P_W'($signed({1'b0, x_q[k_q*X_W +: X_W]}));
        d        = p >>> LR_SHIFT;
        diff     = (P_W+1)'($signed(w_k)) - (P_W+1)'(d);
        w_new    = diff > W_MAX ? W_MAX[W_W-1:0] : diff < W_MIN ? W_MIN[W_W-1:0] : diff[W_W-1:0];
        hp       = H_W'($signed(err_q)) * H_W'($signed(w_k));
        hd       = hp >>> LR_SHIFT;
        herr_new = hd > H_MAX ? H_MAX[ERR_W-1:0] : hd < H_MIN ? H_MIN[ERR_W-1:0] : hd[ERR_W-1:0];
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            k_q          <= '0;
            err_q        <= '0;
            x_q          <= '0;
            done_o       <= 1'b0;
            herr_valid_o <= 1'b0;
            herr_idx_o   <= '0;
            herr_o       <= '0;
            w_flat_o     <= W_DEF;
        end else if (en_i) begin
            state_q      <= state_d;
            done_o       <= state_q == DONE;
            herr_valid_o <= state_q == UPDATE;
            if (state_q == IDLE && start_i) begin
                err_q <= err_i;
                x_q   <= x_flat_i;
                k_q   <= '0;
            end else if (state_q == IDLE && init_i) begin
                w_flat_o <= W_DEF;
            end
            if (state_q == UPDATE) begin
                w_flat_o[k_q*W_W +: W_W] <= w_new;
                herr_o     <= herr_new;
                herr_idx_o <= k_q;
                k_q        <= k_q + 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_output_backprop.sv
// tb_output_backprop: directed and random backprop passes checked against an integer weight model.
module tb_output_backprop;
    logic        clk_i = 1'b0;
    logic        rst_i, en_i, init_i, start_i;
    logic [11:0] err_i;
    logic [79:0] x_flat_i;
    logic        busy_o, done_o, herr_valid_o;
    logic [2:0]  herr_idx_o;
    logic [11:0] herr_o;
    logic [63:0] w_flat_o;

    int total = 0;
    int passed = 0;
    int mw[8];
    int hexp[8];

    output_backprop dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .init_i(init_i), .start_i(start_i),
        .err_i(err_i), .x_flat_i(x_flat_i), .busy_o(busy_o), .done_o(done_o),
        .herr_valid_o(herr_valid_o), .herr_idx_o(herr_idx_o), .herr_o(herr_o),
        .w_flat_o(w_flat_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [79:0] o, input logic [79:0] e);
        total++;
        assert (o === e) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    endtask

    function automatic int sat(input int v, input int lo, input int hi);
        return v < lo ? lo : (v > hi ? hi : v);
    endfunction

    function automatic logic [63:0] mflat();
        logic [63:0] f;
        f = '0;
        for (int k = 0; k < 8; k++) f[k*8 +: 8] = 8'(mw[k]);
        return f;
    endfunction

    function automatic logic [79:0] rep_x(input int v);
        logic [79:0] f;
        f = '0;
        for (int k = 0; k < 8; k++) f[k*10 +: 10] = 10'(v);
        return f;
    endfunction

    function automatic logic [79:0] rand_x();
        logic [79:0] f;
        f = '0;
        for (int k = 0; k < 8; k++) f[k*10 +: 10] = 10'($urandom);
        return f;
    endfunction

    task automatic do_pass(input int e, input logic [79:0] xf, input int stall_at,
                           input int stall_len, input bit repulse, input bit with_init);
        int n, hi, xk;
        logic got_done;
        logic [11:0] he;
        for (int k = 0; k < 8; k++) begin
            xk = int'(xf[k*10 +: 10]);
            hexp[k] = sat((e * mw[k]) >>> 4, -2048, 2047);
            mw[k] = sat(mw[k] - ((e * xk) >>> 4), -128, 127);
        end
        err_i = 12'(e);
        x_flat_i = xf;
        start_i = 1'b1;
        init_i = with_init;
        en_i = 1'b1;
        step();
        init_i = 1'b0;
        err_i = 12'($urandom);
        x_flat_i = rand_x();
        n = 0;
        hi = 0;
        got_done = 1'b0;
        while (n < 60 && !got_done) begin
            en_i = !(n >= stall_at && n < stall_at + stall_len);
            start_i = repulse && (n == 2 || n == 8);
            step();
            n++;
            if (en_i) begin
                if (n == 1) chk("busy_high", busy_o, 1);
                if (herr_valid_o) begin
                    if (hi < 8) begin
                        he = 12'(hexp[hi]);
                        chk("herr_idx", herr_idx_o, hi);
                        chk("herr_val", herr_o, he);
                    end
                    hi++;
                end
                got_done = done_o;
            end
        end
        start_i = 1'b0;
        en_i = 1'b1;
        chk("latency", n, 9 + stall_len);
        chk("herr_count", hi, 8);
        chk("busy_at_done", busy_o, 0);
        chk("weights", w_flat_o, mflat());
        step();
        chk("done_pulse", done_o, 0);
    endtask

    initial begin
        int seen;
        rst_i = 1'b0;
        en_i = 1'b1;
        init_i = 1'b0;
        start_i = 1'b0;
        err_i = '0;
        x_flat_i = '0;
        step();
        step();
        chk("rst_w", w_flat_o, 64'h0807060504030201);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_hv", herr_valid_o, 0);
        chk("rst_herr", {herr_idx_o, herr_o}, 0);
        rst_i = 1'b1;
        for (int k = 0; k < 8; k++) mw[k] = k + 1;
        step();

        do_pass(16, rep_x(1), 0, 0, 0, 0);
        chk("t2_w", w_flat_o, 64'h0706050403020100);
        do_pass(-2048, rep_x(1023), 0, 0, 0, 0);
        chk("t3_sat_hi", w_flat_o, 64'h7f7f7f7f7f7f7f7f);
        do_pass(2047, rep_x(1023), 0, 0, 0, 0);
        chk("t3_sat_lo", w_flat_o, 64'h8080808080808080);
        do_pass(-1, rep_x(1), 0, 0, 0, 0);
        chk("t4_inc", w_flat_o, 64'h8181818181818181);
        do_pass(1, rep_x(1), 0, 0, 0, 0);
        chk("t4_hold", w_flat_o, 64'h8181818181818181);

        do_pass($urandom_range(0, 4095) - 2048, rand_x(), 0, 0, 1, 1);
        chk("repulse_idle", busy_o, 0);
        do_pass($urandom_range(0, 4095) - 2048, rand_x(), 4, 3, 0, 0);
        repeat (4) do_pass($urandom_range(0, 4095) - 2048, rand_x(), 0, 0, 0, 0);

        err_i = 12'd16;
        x_flat_i = rep_x(1);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        repeat (3) step();
        #2 rst_i = 1'b0;
        #1;
        chk("midrst_busy", busy_o, 0);
        chk("midrst_w", w_flat_o, 64'h0807060504030201);
        chk("midrst_done", done_o, 0);
        #2 rst_i = 1'b1;
        for (int k = 0; k < 8; k++) mw[k] = k + 1;
        seen = 0;
        repeat (15) begin
            step();
            if (done_o || busy_o) seen++;
        end
        chk("midrst_quiet", seen, 0);

        do_pass(16, rep_x(1), 0, 0, 0, 0);
        chk("t6_w", w_flat_o, 64'h0706050403020100);
        init_i = 1'b1;
        en_i = 1'b0;
        step();
        chk("init_stalled", w_flat_o, 64'h0706050403020100);
        en_i = 1'b1;
        step();
        init_i = 1'b0;
        chk("init_reload", w_flat_o, 64'h0807060504030201);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
